uart_receiver: RTL and testbench
================================

# uart_receiver

Parametrised UART receive core: the next generation of the board's fixed 8N1 receiver. It adds configurable frame format, a 2-flop input synchroniser, false-start rejection, frame/parity/overrun error reporting and a valid/ready output handshake. It sits between the `uart_rx` pin and any byte consumer (LED driver, command parser, FIFO).

## Interface
- `DELAY_FRAMES`, 234: clock cycles per bit (27 MHz / 115200); legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, 1: stop bits checked; legal values 1 or 2.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `uart_rx`  in  1  serial line, asynchronous, idle high.
- `rx_data`  out  DATA_BITS  received word, LSB first on the line; reset value 0.
- `rx_valid`  out  1  `rx_data` and error flags are valid; reset value 0.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `frame_err`  out  1  first checked stop bit sampled low; qualified by `rx_valid`; reset value 0.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`; reset value 0; tied 0 without the macro.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped; reset value 0.
- `busy`  out  1  FSM is not in IDLE; reset value 0.

## Operation
- `uart_rx` passes through the `uart_rx_sync` 2-flop synchroniser; its flops reset to 1. All decisions use the synchronised line `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when `rxs == 0`, go to START and load the counter with 1.
- START: count to `DELAY_FRAMES/2` (integer division), then re-sample.
  - `rxs == 1`: false start; return to IDLE with no outputs.
  - Otherwise go to DATA with bit index 0.
- DATA: wait `DELAY_FRAMES` cycles, then sample. The sample shifts into the MSB of the shift register, so the word is LSB first. After bit `DATA_BITS-1`, go to PARITY if it is compiled in, else to STOP.
- PARITY: wait `DELAY_FRAMES` cycles and sample. The error is XOR(data, parity bit) ≠ `PARITY_ODD`.
- STOP: wait `DELAY_FRAMES` cycles and sample, once per stop bit.
  - Only the first stop sample sets `frame_err`.
  - The second stop bit is timed but ignored.
- After the last stop sample, the word completes:
  - If `frame_err` is set and `rxs == 0`, go to BREAK; otherwise go to IDLE.
  - A word with errors is still delivered, with its flags set.
- BREAK: hold until `rxs == 1`, then go to IDLE. This prevents retriggering on a held-low line.
- Output register on word completion:
  - Load `rx_data` and the flags, and set `rx_valid`, when `!rx_valid` or `rx_ready` is high in the same cycle. A simultaneous handshake and completion keeps `rx_valid` at 1 and carries the new word.
  - If `rx_valid && !rx_ready`: keep the old word and flags, drop the new word, and pulse `overrun` for 1 cycle.
- A handshake with no completion in that cycle clears `rx_valid`. `rx_data` holds its last value.
- Counter width is `$clog2(DELAY_FRAMES+1)`. The bit index is `$clog2(DATA_BITS+1)` wide. No arithmetic wraps within a frame.
- Reset mid-frame: all state and outputs return to reset values immediately; any partial word is discarded.

## Timing
- Pin to `rxs` latency: 2 cycles.
- Let t0 be the cycle the FSM leaves IDLE.
  - Start re-check at t0 + `DELAY_FRAMES/2`.
  - Data bit i sampled at t0 + `DELAY_FRAMES/2` + (i+1)·`DELAY_FRAMES`.
- `rx_valid` rises on the cycle after the last stop sample. `overrun` pulses in that same cycle.
- Back-to-back frames: IDLE is re-entered the cycle after the last stop sample, so a start bit immediately following is detected with at most 1 cycle of added skew.
- `rx_ready` may be held high permanently; throughput is then one word per frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is present and one parity bit follows the data.
  - `parity_err` is live and `PARITY_ODD` selects the parity sense.
- Not defined:
  - No parity bit is expected; DATA goes directly to STOP.
  - `parity_err` is constant 0 and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding.
  - Parity sense constants `PARITY_EVEN` = 0, `PARITY_ODD_SENSE` = 1.
  - Default `DELAY_FRAMES` (234) for the 27 MHz board clock.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with asynchronous active-low reset to 1. A future `uart_transmitter` reuses the package.

## Test plan
- 8N1 frame of 0x5A with `rx_ready` = 1:
  - `rx_data` = 0x5A and `rx_valid` is 1 for one cycle, at t0 + 117 + 9·234 + 1 cycles.
  - `frame_err` = `parity_err` = 0.
- 50-cycle low glitch on `uart_rx`: no `rx_valid`, and the FSM is back in IDLE by cycle ~120.
- Frame 0x00 with the stop bit low and the line held low 2000 cycles:
  - `rx_valid` with `frame_err` = 1 and `rx_data` = 0x00.
  - No second word until the line goes high and a new start bit arrives.
- Two frames, 0x11 then 0x22, with `rx_ready` = 0: `rx_data` stays 0x11, and `overrun` pulses once at the end of the second frame.
- With `UART_RX_PARITY_EN` and even parity:
  - 0x07 with parity bit 1 gives no error.
  - 0x07 with parity bit 0 gives `parity_err` = 1.
- `rst_n` asserted during data bit 4:
  - All outputs go to 0 and `busy` = 0.
  - After release, the next clean 0xA5 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity sense constants,
// the default bit period for the 27 MHz board clock and a parity helper.
// Imported by uart_receiver and by the future uart_transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam logic PARITY_EVEN      = 1'b0;
  localparam logic PARITY_ODD_SENSE = 1'b1;

  // 27 MHz / 115200 baud
  localparam int DEFAULT_DELAY_FRAMES = 234;

  // Widest supported data word
  localparam int MAX_DATA_BITS = 9;

  // XOR of all bits of a (zero-extended) data word
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so an idle (high) line is seen during and after reset.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous serial input
//   q      out synchronised serial line
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage synchroniser chain, reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// Parametrised UART receive core with 2-flop input synchroniser,
// false-start rejection, frame/parity/overrun reporting and a
// valid/ready output handshake.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data).
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   uart_rx    in  serial line, idle high
//   rx_data    out received word (LSB first on the line)
//   rx_valid   out rx_data and error flags valid
//   rx_ready   in  consumer accepts the word when rx_valid && rx_ready
//   frame_err  out first stop bit sampled low (qualified by rx_valid)
//   parity_err out parity mismatch (qualified by rx_valid), 0 without macro
//   overrun    out one-cycle pulse when a completed word is dropped
//   busy       out FSM is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int   DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int   DATA_BITS    = 8,
  parameter int   STOP_BITS    = 1,
  parameter logic PARITY_ODD   = PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] HALF_C      = CW'(DELAY_FRAMES / 2);
  localparam logic [CW-1:0] FULL_C      = CW'(DELAY_FRAMES);
  localparam logic [IW-1:0] IDX_ONE     = IW'(1);
  localparam logic [IW-1:0] LAST_BIT_C  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP_C = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  logic rxs_s;

  uart_state_e          state_r,    state_nxt;
  logic [CW-1:0]        cnt_r,      cnt_nxt;
  logic [IW-1:0]        bit_idx_r,  bit_idx_nxt;
  logic                 stop_idx_r, stop_idx_nxt;
  logic [DATA_BITS-1:0] shreg_r,    shreg_nxt;
  logic                 ferr_r,     ferr_nxt;
  logic                 done_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 parity_err_r;
  logic                 overrun_r;
  logic                 busy_r;
  logic                 word_perr_s;

`ifdef UART_RX_PARITY_EN
  logic perr_r, perr_nxt;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rxs_s)
  );

  // FSM state and frame datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      shreg_r    <= '0;
      ferr_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      bit_idx_r  <= bit_idx_nxt;
      stop_idx_r <= stop_idx_nxt;
      shreg_r    <= shreg_nxt;
      ferr_r     <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error register for the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_nxt;
    end
  end
`endif

  // Next-state and frame datapath logic; every sample point reloads the
  // bit counter with 1 so samples stay exactly DELAY_FRAMES apart
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    bit_idx_nxt  = bit_idx_r;
    stop_idx_nxt = stop_idx_r;
    shreg_nxt    = shreg_r;
    ferr_nxt     = ferr_r;
    done_s       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt     = perr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rxs_s) begin
          state_nxt = ST_START;
          cnt_nxt   = CNT_ONE;
          ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_nxt  = 1'b0;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_C) begin
          cnt_nxt = CNT_ONE;
          // Line back high at mid start bit: glitch, not a frame
          if (rxs_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == FULL_C) begin
          cnt_nxt   = CNT_ONE;
          shreg_nxt = {rxs_s, shreg_r[DATA_BITS-1:1]};
          if (bit_idx_r == LAST_BIT_C) begin
            stop_idx_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_nxt    = ST_PARITY;
`else
            state_nxt    = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_r + IDX_ONE;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == FULL_C) begin
          cnt_nxt   = CNT_ONE;
          perr_nxt  = parity_of(MAX_DATA_BITS'(shreg_r)) ^ rxs_s ^ PARITY_ODD;
          state_nxt = ST_STOP;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == FULL_C) begin
          cnt_nxt = CNT_ONE;
          // Only the first stop bit is checked
          if (stop_idx_r == 1'b0) begin
            ferr_nxt = !rxs_s;
          end else begin
            ferr_nxt = ferr_r;
          end
          if (stop_idx_r == LAST_STOP_C) begin
            done_s = 1'b1;
            // Line still low after a framing error: treat as break
            if (ferr_nxt && !rxs_s) begin
              state_nxt = ST_BREAK;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_BREAK: begin
        if (rxs_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BREAK;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign word_perr_s = perr_r;
`else
  assign word_perr_s = 1'b0;
`endif

  // Output word register with valid/ready handshake and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (done_s) begin
      if (!rx_valid_r || rx_ready) begin
        rx_data_r    <= shreg_r;
        frame_err_r  <= ferr_nxt;
        parity_err_r <= word_perr_s;
        rx_valid_r   <= 1'b1;
        overrun_r    <= 1'b0;
      end else begin
        // Consumer still holds the previous word: drop the new one
        overrun_r <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  // Registered busy flag, aligned with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt != ST_IDLE);
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at default parameters (234 clocks
// per bit, 8 data bits, 1 stop bit, even parity when UART_RX_PARITY_EN).
module tb_uart_receiver;

  localparam int D    = 234;
  localparam int HALF = 117;
  localparam int DB   = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Frame length in clocks and the clock (counted from the negedge the
  // start bit is driven) after which rx_valid is first seen high:
  // 2 sync cycles + 1 IDLE cycle, half bit, data/parity bits and the stop bit
  localparam int FRAME   = (DB + PB + 2) * D;
  localparam int VALID_K = 3 + HALF + (DB + PB + 1) * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic drive_level(input logic lvl, input int n);
    uart_rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  // One frame; parity bit is even parity inverted when par_flip is set
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_lvl);
    logic par;
    par = (^d) ^ par_flip;
    drive_level(1'b0, D);
    for (int i = 0; i < 8; i++) drive_level(d[i], D);
`ifdef UART_RX_PARITY_EN
    drive_level(par, D);
`endif
    drive_level(stop_lvl, D);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {rx_data, rx_valid, frame_err, parity_err, overrun, busy});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    rx_ready = 1'b1;
    @(negedge clk);
    fork
      send_frame(8'h5A, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= VALID_K + 5; k++) begin
          @(negedge clk);
          if (k == 1000) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
          end
          if (k == VALID_K - 1) begin
            n_checks++;
            if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", rx_valid); end
          end
          if (k == VALID_K) begin
            n_checks++;
            if ({rx_valid, rx_data, frame_err, parity_err} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
              n_fail++;
              $display("FAIL basic_word: got valid=%b data=%h ferr=%b perr=%b expected 1 5a 0 0", rx_valid, rx_data, frame_err, parity_err);
            end
          end
          if (k == VALID_K + 1) begin
            n_checks++;
            if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clear: got %b expected 0", rx_valid); end
          end
        end
      end
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    @(negedge clk);
    fork
      begin drive_level(1'b0, 50); uart_rx = 1'b1; end
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (rx_valid) seen++;
          if (k == 100) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start: got %b expected 1", busy); end
          end
          if (k == 125) begin
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_reject: got %b expected 0", busy); end
          end
        end
      end
    join
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_break();
    int vcnt;
    vcnt = 0;
    rx_ready = 1'b1;
    @(negedge clk);
    fork
      begin drive_level(1'b0, FRAME + 2000); uart_rx = 1'b1; end
      begin
        for (int k = 1; k <= FRAME + 2600; k++) begin
          @(negedge clk);
          if (rx_valid) vcnt++;
          if (k == VALID_K) begin
            n_checks++;
            if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h00, 1'b1}) begin
              n_fail++;
              $display("FAIL break_word: got valid=%b data=%h ferr=%b expected 1 00 1", rx_valid, rx_data, frame_err);
            end
          end
          if (k == VALID_K + 1000) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL break_hold: got busy=%b expected 1", busy); end
          end
        end
      end
    join
    n_checks++;
    if (vcnt != 1) begin n_fail++; $display("FAIL break_words: got %0d valid cycles expected 1", vcnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: got busy=%b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int ocnt;
    int ok_at;
    ocnt  = 0;
    ok_at = -1;
    rx_ready = 1'b0;
    @(negedge clk);
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        drive_level(1'b1, 20);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        for (int k = 1; k <= 2 * FRAME + 100; k++) begin
          @(negedge clk);
          if (overrun) begin ocnt++; ok_at = k; end
        end
      end
    join
    n_checks++;
    if (ocnt != 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ocnt); end
    n_checks++;
    if (ok_at != FRAME + 20 + VALID_K) begin n_fail++; $display("FAIL overrun_time: got %0d expected %0d", ok_at, FRAME + 20 + VALID_K); end
    n_checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL overrun_keep: got valid=%b data=%h expected 1 11", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rx_valid, rx_data} !== {1'b0, 8'h11}) begin
      n_fail++;
      $display("FAIL overrun_handshake: got valid=%b data=%h expected 0 11", rx_valid, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int         at[$];
    rx_ready = 1'b1;
    @(negedge clk);
    fork
      begin
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
      end
      begin
        for (int k = 1; k <= 2 * FRAME + 100; k++) begin
          @(negedge clk);
          if (rx_valid) begin got.push_back(rx_data); at.push_back(k); end
        end
      end
    join
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words expected 2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'h3C || got[1] !== 8'hC3) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h expected 3c c3", got[0], got[1]);
      end
      n_checks++;
      if (at[0] != VALID_K || at[1] != FRAME + VALID_K) begin
        n_fail++;
        $display("FAIL b2b_time: got %0d %0d expected %0d %0d", at[0], at[1], VALID_K, FRAME + VALID_K);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [1:0] perrs;
    int         n;
    n = 0;
    perrs = 2'b00;
    rx_ready = 1'b1;
    @(negedge clk);
    fork
      begin
        send_frame(8'h07, 1'b0, 1'b1);
        drive_level(1'b1, 20);
        send_frame(8'h07, 1'b1, 1'b1);
      end
      begin
        for (int k = 1; k <= 2 * FRAME + 100; k++) begin
          @(negedge clk);
          if (rx_valid && n < 2) begin perrs[n] = parity_err; n++; end
        end
      end
    join
    n_checks++;
    if (n != 2 || perrs !== 2'b10) begin
      n_fail++;
      $display("FAIL parity_flags: got %0d words flags=%b expected 2 words flags=10", n, perrs);
    end
  endtask
`endif

  task automatic test_reset_mid();
    rx_ready = 1'b1;
    @(negedge clk);
    drive_level(1'b0, D);
    drive_level(1'b1, D);
    drive_level(1'b0, D);
    drive_level(1'b1, D);
    drive_level(1'b0, D);
    drive_level(1'b0, 100);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0", {rx_data, rx_valid, frame_err, parity_err, overrun, busy});
    end
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= VALID_K + 5; k++) begin
          @(negedge clk);
          if (k == VALID_K) begin
            n_checks++;
            if ({rx_valid, rx_data, frame_err, parity_err} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
              n_fail++;
              $display("FAIL midreset_next: got valid=%b data=%h ferr=%b perr=%b expected 1 a5 0 0", rx_valid, rx_data, frame_err, parity_err);
            end
          end
        end
      end
    join
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    repeat (50) @(negedge clk);
    test_overrun();
    repeat (50) @(negedge clk);
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    repeat (50) @(negedge clk);
    test_parity();
`endif
    repeat (50) @(negedge clk);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
